// File: rtl/ecc_mont_sequencer_if.sv
// Bundle of host, domain-transfer and point-core signals around the ECC Montgomery sequencer.
// The slave modport is the sequencer's view. The master modport is the environment's view.
interface ecc_mont_sequencer_if #(
  parameter int W = 32
) ();
  logic         start;
  logic [W-1:0] px_in;
  logic [W-1:0] py_in;
  logic [W-1:0] a_in;
  logic [W-1:0] prime_in;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] px_res;
  logic [W-1:0] py_res;
  logic         dt_start;
  logic         dt_to_mont;
  logic [W-1:0] dt_px;
  logic [W-1:0] dt_py;
  logic [W-1:0] dt_a;
  logic [W-1:0] dt_prime;
  logic [W-1:0] dt_px_o;
  logic [W-1:0] dt_py_o;
  logic [W-1:0] dt_a_o;
  logic         dt_done;
  logic         core_start;
  logic [W-1:0] core_px;
  logic [W-1:0] core_py;
  logic [W-1:0] core_a;
  logic [W-1:0] core_px_o;
  logic [W-1:0] core_py_o;
  logic         core_done;

  modport slave (
    input  start, px_in, py_in, a_in, prime_in,
    input  dt_px_o, dt_py_o, dt_a_o, dt_done, core_px_o, core_py_o, core_done,
    output busy, done, err, px_res, py_res,
    output dt_start, dt_to_mont, dt_px, dt_py, dt_a, dt_prime,
    output core_start, core_px, core_py, core_a
  );

  modport master (
    output start, px_in, py_in, a_in, prime_in,
    output dt_px_o, dt_py_o, dt_a_o, dt_done, core_px_o, core_py_o, core_done,
    input  busy, done, err, px_res, py_res,
    input  dt_start, dt_to_mont, dt_px, dt_py, dt_a, dt_prime,
    input  core_start, core_px, core_py, core_a
  );
endinterface

// File: rtl/ecc_mont_sequencer.sv
// Sequences one ECC point operation in three steps: convert to the Montgomery domain, run the point core, then convert back.
// A per-wait watchdog aborts to ERR if the downstream unit stays silent for too long.
//
// state     | meaning
// IDLE      | waiting for start; operands captured on start
// FWD_REQ   | pulse dt_start with to_mont=1
// FWD_WAIT  | wait dt_done; Montgomery operands go to core_*
// CORE_REQ  | pulse core_start
// CORE_WAIT | wait core_done; core results go back to dt_*
// INV_REQ   | pulse dt_start with to_mont=0
// INV_WAIT  | wait dt_done; regular-domain results captured
// FIN       | done pulse, result valid
// ERR       | done+err pulse, result zeroed
module ecc_mont_sequencer #(
  parameter int W       = 32,
  parameter int TIMEOUT = 4096,
  parameter int TW      = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  ecc_mont_sequencer_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FWD_REQ   = 4'd1,
    FWD_WAIT  = 4'd2,
    CORE_REQ  = 4'd3,
    CORE_WAIT = 4'd4,
    INV_REQ   = 4'd5,
    INV_WAIT  = 4'd6,
    FIN       = 4'd7,
    ERR       = 4'd8
  } state_e;

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] wd_q, wd_d;
  logic [W-1:0]  dt_px_q, dt_py_q, dt_a_q, dt_prime_q;
  logic [W-1:0]  core_px_q, core_py_q, core_a_q;
  logic [W-1:0]  px_res_q, py_res_q;

  logic cap_en, fwd_ld, core_ld, inv_ld, tmo;
  logic wd_exp;
  logic in_wait;

  assign wd_exp  = (wd_q == WD_LAST);
  assign in_wait = (state_q == FWD_WAIT) || (state_q == CORE_WAIT) || (state_q == INV_WAIT);

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    fwd_ld  = 1'b0;
    core_ld = 1'b0;
    inv_ld  = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cap_en  = 1'b1;
          state_d = FWD_REQ;
        end
      end
      FWD_REQ:  state_d = FWD_WAIT;
      FWD_WAIT: begin
        // A completion in the expiry cycle still counts as success.
        if (bus.dt_done) begin
          fwd_ld  = 1'b1;
          state_d = CORE_REQ;
        end else if (wd_exp) begin
          tmo     = 1'b1;
          state_d = ERR;
        end
      end
      CORE_REQ:  state_d = CORE_WAIT;
      CORE_WAIT: begin
        if (bus.core_done) begin
          core_ld = 1'b1;
          state_d = INV_REQ;
        end else if (wd_exp) begin
          tmo     = 1'b1;
          state_d = ERR;
        end
      end
      INV_REQ:  state_d = INV_WAIT;
      INV_WAIT: begin
        if (bus.dt_done) begin
          inv_ld  = 1'b1;
          state_d = FIN;
        end else if (wd_exp) begin
          tmo     = 1'b1;
          state_d = ERR;
        end
      end
      FIN:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Every WAIT is entered from its REQ state, so staying put is the only case that counts.
    wd_d = '0;
    if (in_wait && (state_d == state_q)) begin
      wd_d = wd_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wd_q       <= '0;
      dt_px_q    <= '0;
      dt_py_q    <= '0;
      dt_a_q     <= '0;
      dt_prime_q <= '0;
      core_px_q  <= '0;
      core_py_q  <= '0;
      core_a_q   <= '0;
      px_res_q   <= '0;
      py_res_q   <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if (cap_en) begin
        dt_px_q    <= bus.px_in;
        dt_py_q    <= bus.py_in;
        dt_a_q     <= bus.a_in;
        dt_prime_q <= bus.prime_in;
      end
      if (fwd_ld) begin
        core_px_q <= bus.dt_px_o;
        core_py_q <= bus.dt_py_o;
        core_a_q  <= bus.dt_a_o;
      end
      // The inverse pass carries Montgomery A so that all three dt operands stay in one domain.
      if (core_ld) begin
        dt_px_q <= bus.core_px_o;
        dt_py_q <= bus.core_py_o;
        dt_a_q  <= core_a_q;
      end
      if (inv_ld) begin
        px_res_q <= bus.dt_px_o;
        py_res_q <= bus.dt_py_o;
      end
      if (tmo) begin
        px_res_q <= '0;
        py_res_q <= '0;
      end
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == FIN) || (state_q == ERR);
  assign bus.err        = (state_q == ERR);
  assign bus.px_res     = px_res_q;
  assign bus.py_res     = py_res_q;
  assign bus.dt_start   = (state_q == FWD_REQ) || (state_q == INV_REQ);
  assign bus.dt_to_mont = (state_q == FWD_REQ) || (state_q == FWD_WAIT);
  assign bus.dt_px      = dt_px_q;
  assign bus.dt_py      = dt_py_q;
  assign bus.dt_a       = dt_a_q;
  assign bus.dt_prime   = dt_prime_q;
  assign bus.core_start = (state_q == CORE_REQ);
  assign bus.core_px    = core_px_q;
  assign bus.core_py    = core_py_q;
  assign bus.core_a     = core_a_q;

endmodule

// File: tb/tb_ecc_mont_sequencer.sv
// Scoreboard bench for ecc_mont_sequencer with behavioural domain-transfer and identity point-core stubs.
// The stubs have programmable latency and can inject stray completion pulses.
module tb_ecc_mont_sequencer;
  localparam int W = 32;

  logic clk;
  logic reset;
  ecc_mont_sequencer_if #(.W(W)) bus ();

  ecc_mont_sequencer #(.W(W), .TIMEOUT(16), .TW(13)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic         err;
    logic [W-1:0] px;
    logic [W-1:0] py;
    int           lat;
    int           start_cyc;
  } exp_t;

  exp_t         expq[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           dt_lat = 1;
  int           core_lat = 1;
  bit           core_hang = 0;
  int           inj_dt_cyc = -1;
  int           inj_core_cyc = -1;
  bit           mont_log[$];
  logic [W-1:0] cap_core_px, cap_core_py, inv_a, inv_prime;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [W-1:0] to_mont(input logic [W-1:0] x, input logic [W-1:0] p);
    logic [63:0] t;
    t = ({32'h0, x} << 32) % {32'h0, p};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] from_mont(input logic [W-1:0] x, input logic [W-1:0] p);
    for (logic [W-1:0] y = '0; y < p; y++) begin
      if (to_mont(y, p) == (x % p)) return y;
    end
    return '0;
  endfunction

  // Domain-transfer stub: real Montgomery conversion, dt_lat cycles after dt_start.
  initial begin
    int           cnt;
    logic [W-1:0] rx, ry, ra;
    cnt = 0;
    rx = '0; ry = '0; ra = '0;
    bus.dt_done = 1'b0;
    bus.dt_px_o = '0;
    bus.dt_py_o = '0;
    bus.dt_a_o  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.dt_done = 1'b0;
      if (reset) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.dt_done = 1'b1;
            bus.dt_px_o = rx;
            bus.dt_py_o = ry;
            bus.dt_a_o  = ra;
          end
        end
        if (cyc == inj_dt_cyc) begin
          bus.dt_done = 1'b1;
          bus.dt_px_o = 32'hBAD;
          bus.dt_py_o = 32'hBAD;
          bus.dt_a_o  = 32'hBAD;
        end
        if (bus.dt_start) begin
          mont_log.push_back(bus.dt_to_mont);
          cnt = dt_lat;
          if (bus.dt_to_mont) begin
            rx = to_mont(bus.dt_px, bus.dt_prime);
            ry = to_mont(bus.dt_py, bus.dt_prime);
            ra = to_mont(bus.dt_a, bus.dt_prime);
          end else begin
            inv_a     = bus.dt_a;
            inv_prime = bus.dt_prime;
            rx = from_mont(bus.dt_px, bus.dt_prime);
            ry = from_mont(bus.dt_py, bus.dt_prime);
            ra = from_mont(bus.dt_a, bus.dt_prime);
          end
        end
      end
    end
  end

  // Identity point-core stub.
  initial begin
    int cnt;
    cnt = 0;
    bus.core_done = 1'b0;
    bus.core_px_o = '0;
    bus.core_py_o = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.core_done = 1'b0;
      if (reset) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.core_done = 1'b1;
            bus.core_px_o = cap_core_px;
            bus.core_py_o = cap_core_py;
          end
        end
        if (cyc == inj_core_cyc) begin
          bus.core_done = 1'b1;
          bus.core_px_o = 32'hBAD;
          bus.core_py_o = 32'hBAD;
        end
        if (bus.core_start) begin
          cap_core_px = bus.core_px;
          cap_core_py = bus.core_py;
          if (!core_hang) cnt = core_lat;
        end
      end
    end
  end

  // Monitor: every done pops one expected result.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && bus.done) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
        end else begin
          x = expq.pop_front();
          chk("done_err", {63'h0, bus.err}, {63'h0, x.err});
          chk("px_res", {32'h0, bus.px_res}, {32'h0, x.px});
          chk("py_res", {32'h0, bus.py_res}, {32'h0, x.py});
          chk("latency", 64'(cyc - x.start_cyc + 1), 64'(x.lat));
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] px, input logic [W-1:0] py, input logic [W-1:0] a,
                       input logic [W-1:0] p, input logic e, input logic [W-1:0] ex,
                       input logic [W-1:0] ey, input int lat, input bit push);
    exp_t x;
    bus.px_in    = px;
    bus.py_in    = py;
    bus.a_in     = a;
    bus.prime_in = p;
    bus.start    = 1'b1;
    if (push) begin
      x.err = e; x.px = ex; x.py = ey; x.lat = lat; x.start_cyc = cyc;
      expq.push_back(x);
    end
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 300) begin
      step(1);
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles expected busy=0", n);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {58'h0, bus.busy, bus.done, bus.err, bus.dt_start, bus.dt_to_mont, bus.core_start}, 64'h0);
    chk({tag, "_res"}, {bus.px_res, bus.py_res}, 64'h0);
    chk({tag, "_dt_ops"}, {32'h0, bus.dt_px | bus.dt_py | bus.dt_a | bus.dt_prime}, 64'h0);
    chk({tag, "_core_ops"}, {32'h0, bus.core_px | bus.core_py | bus.core_a}, 64'h0);
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.px_in    = '0;
    bus.py_in    = '0;
    bus.a_in     = '0;
    bus.prime_in = '0;
    step(3);
    check_zero("reset");
    reset = 1'b0;
    step(2);

    // Unit-latency stubs: 8 cycles inclusive, forward then inverse transfer.
    dt_lat = 1; core_lat = 1;
    mont_log.delete();
    issue(5, 7, 2, 97, 1'b0, 5, 7, 8, 1'b1);
    wait_idle();
    chk("dt_start_count", 64'(mont_log.size()), 64'd2);
    if (mont_log.size() == 2) begin
      chk("first_to_mont", {63'h0, mont_log[0]}, 64'd1);
      chk("second_to_mont", {63'h0, mont_log[1]}, 64'd0);
    end

    // Montgomery values for Prime=97: 5*2^32 mod 97 = 78, 7*2^32 mod 97 = 51, 2*2^32 mod 97 = 70.
    dt_lat = 2; core_lat = 3;
    issue(5, 7, 2, 97, 1'b0, 5, 7, 12, 1'b1);
    wait_idle();
    chk("core_px_mont", {32'h0, cap_core_px}, 64'd78);
    chk("core_py_mont", {32'h0, cap_core_py}, 64'd51);
    chk("inv_dt_a_mont", {32'h0, inv_a}, 64'd70);
    chk("inv_dt_prime", {32'h0, inv_prime}, 64'd97);

    // The core never answers, so CORE_WAIT expires after 16 cycles.
    dt_lat = 1; core_hang = 1;
    issue(11, 13, 3, 101, 1'b1, 0, 0, 21, 1'b1);
    n = 0;
    while (!bus.done && n < 100) begin
      step(1);
      n++;
    end
    chk("tmo_done", {63'h0, bus.done}, 64'd1);
    chk("tmo_err", {63'h0, bus.err}, 64'd1);
    step(1);
    chk("tmo_busy_after", {62'h0, bus.busy, bus.done}, 64'd0);
    core_hang = 0;

    // Each completion arrives on the last watchdog cycle, so done wins.
    dt_lat = 16; core_lat = 1;
    issue(200, 17, 9, 251, 1'b0, 200, 17, 38, 1'b1);
    wait_idle();
    // One cycle too late, so the forward wait aborts.
    dt_lat = 17;
    issue(200, 17, 9, 251, 1'b1, 0, 0, 19, 1'b1);
    wait_idle();
    step(20);

    // Starts issued during FWD_WAIT and during FIN are dropped; a start in the following IDLE cycle is accepted.
    dt_lat = 1; core_lat = 1;
    issue(3, 4, 1, 97, 1'b0, 3, 4, 8, 1'b1);
    step(1);
    bus.px_in = 1; bus.py_in = 1; bus.a_in = 1; bus.prime_in = 13;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(4);
    chk("fin_seen", {63'h0, bus.done}, 64'd1);
    bus.start = 1'b1;
    step(1);
    issue(60, 90, 5, 101, 1'b0, 60, 90, 8, 1'b1);
    wait_idle();

    // Reset during CORE_WAIT, followed by a clean run.
    core_lat = 10;
    issue(8, 9, 1, 97, 1'b0, 0, 0, 0, 1'b0);
    step(3);
    chk("pre_reset_busy", {63'h0, bus.busy}, 64'd1);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midrst");
    step(1);
    reset = 1'b0;
    step(1);
    core_lat = 1;
    issue(11, 13, 3, 101, 1'b0, 11, 13, 8, 1'b1);
    wait_idle();

    // Stray core_done in FWD_WAIT and stray dt_done in CORE_WAIT must not move the FSM.
    dt_lat = 3; core_lat = 3;
    issue(42, 24, 6, 251, 1'b0, 42, 24, 14, 1'b1);
    inj_core_cyc = cyc + 1;
    inj_dt_cyc   = cyc + 5;
    wait_idle();
    inj_core_cyc = -1;
    inj_dt_cyc   = -1;

    step(5);
    chk("scoreboard_empty", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
